running_mean_sched: RTL and testbench

- Time-multiplexes one shared `running_mean` unit among NUM_CH distance-stream requesters in the KNN accelerator.
- Grants the unit to one requester for a burst of exactly WINDOW_SIZE samples, then forwards samples to the unit and captures its mean.
- Returns the mean tagged with the channel ID, then clears the unit before the next grant.
- Sits between the distance-compute lanes and the single `running_mean` instance.

---
 rtl/running_mean_sched_pkg.sv | 21 ++
 rtl/running_mean_sched_rr_arbiter.sv | 37 +++
 rtl/running_mean_sched.sv | 213 +++++++++++++++++++++
 tb/tb_running_mean_sched.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/running_mean_sched_pkg.sv
// Shared definitions for the running_mean scheduler: FSM state encoding,
// channel-ID width helper and default timing constants.
package rmean_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STREAM = 3'd1,
    S_DRAIN  = 3'd2,
    S_RESULT = 3'd3,
    S_CLEAR  = 3'd4
  } rmean_sched_state_t;

  localparam int RMEAN_CLEAR_CYCLES_DEF  = 2;
  localparam int RMEAN_DRAIN_TIMEOUT_DEF = 32;

  // Width of a channel index; never narrower than one bit.
  function automatic int ch_id_width(input int num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/running_mean_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// the pointer, wrapping from NUM_CH-1 back to 0.
module rr_arbiter
  import rmean_pkg::*;
#(
  parameter int  NUM_CH = 4,
  localparam int CH_W   = ch_id_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [CH_W-1:0]   gnt_idx_o
);

  // Scan upward from the pointer and keep the first active request.
  always_comb begin
    int          j;
    logic [CH_W-1:0] idx;
    logic        found;
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    j         = 0;
    idx       = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NUM_CH) j = j - NUM_CH;
      idx = CH_W'(j);
      if (!found && req_i[idx]) begin
        found       = 1'b1;
        gnt_o[idx]  = 1'b1;
        gnt_idx_o   = idx;
      end
    end
  end

endmodule

// File: rtl/running_mean_sched.sv
// Time-multiplexes one shared running_mean unit among NUM_CH requesters.
// A granted channel streams exactly WINDOW_SIZE samples into the unit, the
// resulting mean is returned tagged with the channel, and the unit is then
// cleared before the next grant.
//
// Optional build macro RMEAN_SCHED_TIMEOUT_EN adds a res_err output and a
// DRAIN watchdog; without it DRAIN waits for the unit indefinitely.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | no owner; arbitrate among req_valid
// S_STREAM | owner streams samples, forwarded one cycle after handshake
// S_DRAIN  | window complete; wait for the unit's mean
// S_RESULT | hold res_valid/res_data/res_ch until res_ready
// S_CLEAR  | hold mu_clear_n low for CLEAR_CYCLES cycles
module running_mean_sched
  import rmean_pkg::*;
#(
  parameter int  DATA_WIDTH    = 16,
  parameter int  WINDOW_SIZE   = 8,
  parameter int  NUM_CH        = 4,
  parameter int  CLEAR_CYCLES  = RMEAN_CLEAR_CYCLES_DEF,
  parameter int  DRAIN_TIMEOUT = RMEAN_DRAIN_TIMEOUT_DEF,
  localparam int CH_W          = ch_id_width(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            req_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] req_data,
  output logic [NUM_CH-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]        mu_data_in,
  output logic                         mu_valid_in,
  input  logic [DATA_WIDTH-1:0]        mu_mean_out,
  input  logic                         mu_valid_out,
  output logic                         mu_clear_n,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [DATA_WIDTH-1:0]        res_data,
  output logic [CH_W-1:0]              res_ch
`ifdef RMEAN_SCHED_TIMEOUT_EN
  ,
  output logic                         res_err
`endif
);

  localparam int CNT_W = $clog2(WINDOW_SIZE + 1);
  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  rmean_sched_state_t state_q, state_d;
  logic [CH_W-1:0]       owner_q, owner_d;
  logic [CH_W-1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CLR_W-1:0]      clr_cnt_q, clr_cnt_d;
  logic [DATA_WIDTH-1:0] mu_data_q, mu_data_d;
  logic                  mu_valid_q, mu_valid_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic [CH_W-1:0]       res_ch_q, res_ch_d;

`ifdef RMEAN_SCHED_TIMEOUT_EN
  localparam int TMO_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic                  res_err_q, res_err_d;
`endif

  logic [NUM_CH-1:0]     gnt_oh;
  logic [CH_W-1:0]       gnt_idx;
  logic                  gnt_any;
  logic [DATA_WIDTH-1:0] own_data;
  logic                  own_valid;
  logic                  hs;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt_oh),
    .gnt_idx_o (gnt_idx)
  );

  assign gnt_any = |gnt_oh;

  // Select the owner's request lane and drive its ready while streaming.
  always_comb begin
    own_data  = '0;
    own_valid = 1'b0;
    req_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (owner_q == CH_W'(i)) begin
        own_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        own_valid = req_valid[i];
        if (state_q == S_STREAM) req_ready[i] = 1'b1;
      end
    end
  end

  assign hs = (state_q == S_STREAM) && own_valid;

  // Next-state and datapath updates for the scheduler FSM.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    clr_cnt_d  = clr_cnt_q;
    mu_data_d  = mu_data_q;
    mu_valid_d = 1'b0;
    res_data_d = res_data_q;
    res_ch_d   = res_ch_q;
`ifdef RMEAN_SCHED_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
    res_err_d  = res_err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          owner_d = gnt_idx;
          cnt_d   = '0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (hs) begin
          mu_data_d  = own_data;
          mu_valid_d = 1'b1;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WINDOW_SIZE - 1)) begin
            state_d = S_DRAIN;
`ifdef RMEAN_SCHED_TIMEOUT_EN
            tmo_cnt_d = TMO_W'(DRAIN_TIMEOUT - 1);
`endif
          end
        end
      end
      S_DRAIN: begin
        if (mu_valid_out) begin
          res_data_d = mu_mean_out;
          res_ch_d   = owner_q;
          state_d    = S_RESULT;
`ifdef RMEAN_SCHED_TIMEOUT_EN
          res_err_d  = 1'b0;
`endif
        end
`ifdef RMEAN_SCHED_TIMEOUT_EN
        else if (tmo_cnt_q == '0) begin
          res_data_d = '0;
          res_ch_d   = owner_q;
          res_err_d  = 1'b1;
          state_d    = S_RESULT;
        end else begin
          tmo_cnt_d = tmo_cnt_q - 1'b1;
        end
`endif
      end
      S_RESULT: begin
        if (res_ready) begin
          state_d   = S_CLEAR;
          clr_cnt_d = CLR_W'(CLEAR_CYCLES - 1);
          ptr_d     = (owner_q == CH_W'(NUM_CH - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      S_CLEAR: begin
        if (clr_cnt_q == '0) state_d = S_IDLE;
        else                 clr_cnt_d = clr_cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      clr_cnt_q  <= '0;
      mu_data_q  <= '0;
      mu_valid_q <= 1'b0;
      res_data_q <= '0;
      res_ch_q   <= '0;
`ifdef RMEAN_SCHED_TIMEOUT_EN
      tmo_cnt_q  <= '0;
      res_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      clr_cnt_q  <= clr_cnt_d;
      mu_data_q  <= mu_data_d;
      mu_valid_q <= mu_valid_d;
      res_data_q <= res_data_d;
      res_ch_q   <= res_ch_d;
`ifdef RMEAN_SCHED_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
      res_err_q  <= res_err_d;
`endif
    end
  end

  assign mu_data_in  = mu_data_q;
  assign mu_valid_in = mu_valid_q;
  assign mu_clear_n  = (state_q != S_CLEAR);
  assign res_valid   = (state_q == S_RESULT);
  assign res_data    = res_data_q;
  assign res_ch      = res_ch_q;
`ifdef RMEAN_SCHED_TIMEOUT_EN
  assign res_err     = res_err_q;
`endif

endmodule

// File: tb/tb_running_mean_sched.sv
`timescale 1ns/1ps
module tb_running_mean_sched;
  import rmean_pkg::*;

  localparam int DW  = 16;
  localparam int WS  = 8;
  localparam int NCH = 4;
  localparam int CLR = 2;
  localparam int TMO = 32;
  localparam int CHW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH-1:0]    req_valid;
  logic [NCH*DW-1:0] req_data;
  logic [NCH-1:0]    req_ready;
  logic [DW-1:0]     mu_data_in;
  logic              mu_valid_in;
  logic [DW-1:0]     mu_mean_out;
  logic              mu_valid_out;
  logic              mu_clear_n;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [DW-1:0]     res_data;
  logic [CHW-1:0]    res_ch;
`ifdef RMEAN_SCHED_TIMEOUT_EN
  logic              res_err;
`endif

  logic          ch_valid [NCH];
  logic [DW-1:0] ch_data  [NCH];
  logic          model_dis = 1'b0;

  typedef struct {
    logic [DW-1:0] data;
    int            ch;
    bit            err;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int fwd_count = 0;
  int clr_runs  = 0;
  int n_results = 0;

  running_mean_sched #(
    .DATA_WIDTH    (DW),
    .WINDOW_SIZE   (WS),
    .NUM_CH        (NCH),
    .CLEAR_CYCLES  (CLR),
    .DRAIN_TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .mu_data_in   (mu_data_in),
    .mu_valid_in  (mu_valid_in),
    .mu_mean_out  (mu_mean_out),
    .mu_valid_out (mu_valid_out),
    .mu_clear_n   (mu_clear_n),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_ch       (res_ch)
`ifdef RMEAN_SCHED_TIMEOUT_EN
    ,
    .res_err      (res_err)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    req_valid = '0;
    req_data  = '0;
    for (int i = 0; i < NCH; i++) begin
      req_valid[i]           = ch_valid[i];
      req_data[i*DW +: DW]   = ch_data[i];
    end
  end

  // Stand-in for the shared running_mean unit: averages WS samples, then
  // holds the mean valid until cleared.
  logic unit_rst_n;
  assign unit_rst_n = rst_n & mu_clear_n;
  int          m_cnt;
  logic [31:0] m_sum;
  always @(posedge clk or negedge unit_rst_n) begin
    if (!unit_rst_n) begin
      m_cnt        <= 0;
      m_sum        <= '0;
      mu_valid_out <= 1'b0;
      mu_mean_out  <= '0;
    end else if (mu_valid_in && m_cnt < WS) begin
      m_sum <= m_sum + 32'(mu_data_in);
      m_cnt <= m_cnt + 1;
      if (m_cnt == WS - 1 && !model_dis) begin
        mu_valid_out <= 1'b1;
        mu_mean_out  <= DW'((m_sum + 32'(mu_data_in)) / WS);
      end
    end
  end

  function automatic int exp_mean(input int base, input int step);
    return (WS * base + step * (WS * (WS - 1) / 2)) / WS;
  endfunction

  task automatic push_exp(input int v, input int c, input bit err);
    exp_t e;
    e.data = DW'(v);
    e.ch   = c;
    e.err  = err;
    exp_q.push_back(e);
  endtask

  // Monitor: forwarding latency, ready exclusivity, result scoreboard,
  // result hold/release and clear-pulse length.
  initial begin : monitor
    logic          pend_hs;
    logic [DW-1:0] pend_data;
    logic          prev_hold, prev_hs;
    logic [DW-1:0] prev_data;
    logic [CHW-1:0] prev_ch;
    int            clr_len;
    exp_t          e;
    pend_hs = 1'b0; pend_data = '0; prev_hold = 1'b0; prev_hs = 1'b0;
    prev_data = '0; prev_ch = '0; clr_len = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend_hs = 1'b0; prev_hold = 1'b0; prev_hs = 1'b0; clr_len = 0;
      end else begin
        if (mu_valid_in === 1'b1) fwd_count++;
        if (pend_hs) begin
          n_checks++;
          if (mu_valid_in !== 1'b1 || mu_data_in !== pend_data) begin
            n_fail++;
            $display("FAIL fwd_sample: mu_valid_in=%b mu_data_in=%0d, required 1/%0d", mu_valid_in, mu_data_in, pend_data);
          end
        end else if (mu_valid_in !== 1'b0) begin
          n_checks++; n_fail++;
          $display("FAIL spurious_fwd: mu_valid_in=%b with no prior handshake, required 0", mu_valid_in);
        end
        n_checks++;
        if (!$onehot0(req_ready)) begin
          n_fail++;
          $display("FAIL ready_onehot: req_ready=%b, required at most one bit", req_ready);
        end
        if (prev_hs) begin
          n_checks++;
          if (res_valid !== 1'b0 || mu_clear_n !== 1'b0) begin
            n_fail++;
            $display("FAIL res_release: res_valid=%b mu_clear_n=%b, required 0/0", res_valid, mu_clear_n);
          end
        end
        if (prev_hold) begin
          n_checks++;
          if (res_valid !== 1'b1 || res_data !== prev_data || res_ch !== prev_ch) begin
            n_fail++;
            $display("FAIL res_stable: res_valid=%b data=%0d ch=%0d, required 1/%0d/%0d", res_valid, res_data, res_ch, prev_data, prev_ch);
          end
        end
        if (res_valid === 1'b1 && res_ready === 1'b1) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_result: data=%0d ch=%0d, required no result", res_data, res_ch);
          end else begin
            e = exp_q.pop_front();
            n_results++;
            if (res_data !== e.data || res_ch !== CHW'(e.ch)) begin
              n_fail++;
              $display("FAIL result: data=%0d ch=%0d, required %0d/%0d", res_data, res_ch, e.data, e.ch);
            end
`ifdef RMEAN_SCHED_TIMEOUT_EN
            n_checks++;
            if (res_err !== e.err) begin
              n_fail++;
              $display("FAIL result_err: res_err=%b, required %b", res_err, e.err);
            end
`endif
          end
        end
        prev_hs   = (res_valid === 1'b1) && (res_ready === 1'b1);
        prev_hold = (res_valid === 1'b1) && (res_ready !== 1'b1);
        prev_data = res_data;
        prev_ch   = res_ch;
        if (mu_clear_n === 1'b0) begin
          clr_len++;
        end else if (clr_len != 0) begin
          n_checks++;
          clr_runs++;
          if (clr_len != CLR) begin
            n_fail++;
            $display("FAIL clear_len: mu_clear_n low %0d cycles, required %0d", clr_len, CLR);
          end
          clr_len = 0;
        end
        pend_hs = 1'b0;
        for (int i = 0; i < NCH; i++) begin
          if (req_valid[i] && req_ready[i] === 1'b1) begin
            pend_hs   = 1'b1;
            pend_data = ch_data[i];
          end
        end
      end
    end
  end

  // Streams n samples base, base+step, ... on channel ch; optional gap before sample gap_at.
  task automatic drive_burst(input int ch, input int n, input int base, input int step,
                             input int gap_at, input int gap_len);
    int w;
    for (int k = 0; k < n; k++) begin
      if (k == gap_at) begin
        ch_valid[ch] = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end
      ch_data[ch]  = DW'(base + k * step);
      ch_valid[ch] = 1'b1;
      w = 0;
      @(negedge clk);
      while (req_ready[ch] !== 1'b1 && w < 2000) begin
        @(negedge clk);
        w++;
      end
      if (w >= 2000) begin
        n_checks++; n_fail++;
        $display("FAIL grant_timeout: ch%0d sample %0d req_ready=%b, required bit set", ch, k, req_ready);
        ch_valid[ch] = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    ch_valid[ch] = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) begin
      n_checks++; n_fail++;
      $display("FAIL %s_drain: %0d results outstanding, required 0", name, exp_q.size());
    end
    repeat (CLR + 3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (req_ready !== '0 || mu_valid_in !== 1'b0 || mu_data_in !== '0 || mu_clear_n !== 1'b1 ||
        res_valid !== 1'b0 || res_data !== '0 || res_ch !== '0) begin
      n_fail++;
      $display("FAIL reset_values: rdy=%b mvi=%b mdi=%0d clr=%b rv=%b rd=%0d rc=%0d, required 0/0/0/1/0/0/0",
               req_ready, mu_valid_in, mu_data_in, mu_clear_n, res_valid, res_data, res_ch);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (req_ready !== '0 || res_valid !== 1'b0 || mu_clear_n !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_after_reset: rdy=%b rv=%b clr=%b, required 0/0/1", req_ready, res_valid, mu_clear_n);
    end
  endtask

  task automatic test_single();
    int f0, c0;
    f0 = fwd_count;
    c0 = clr_runs;
    push_exp(45, 0, 1'b0);
    drive_burst(0, WS, 10, 10, -1, 0);
    wait_idle("single");
    n_checks++;
    if (fwd_count - f0 != WS) begin
      n_fail++;
      $display("FAIL single_fwd_count: %0d samples forwarded, required %0d", fwd_count - f0, WS);
    end
    n_checks++;
    if (clr_runs - c0 != 1) begin
      n_fail++;
      $display("FAIL single_clear_runs: %0d clear pulses, required 1", clr_runs - c0);
    end
  endtask

  task automatic test_contention();
    int c0;
    c0 = clr_runs;
    push_exp(exp_mean(300, 3), 1, 1'b0);
    push_exp(exp_mean(500, 5), 3, 1'b0);
    fork
      drive_burst(1, WS, 300, 3, -1, 0);
      drive_burst(3, WS, 500, 5, -1, 0);
    join
    wait_idle("contention");
    n_checks++;
    if (clr_runs - c0 != 2) begin
      n_fail++;
      $display("FAIL contention_clear_runs: %0d clear pulses, required 2", clr_runs - c0);
    end
  endtask

  task automatic test_fairness();
    int r0;
    r0 = n_results;
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < NCH; c++)
        push_exp(exp_mean(40 + 100 * c + b * WS * (c + 1), c + 1), c, 1'b0);
    fork
      drive_burst(0, 2 * WS, 40,  1, -1, 0);
      drive_burst(1, 2 * WS, 140, 2, -1, 0);
      drive_burst(2, 2 * WS, 240, 3, -1, 0);
      drive_burst(3, 2 * WS, 340, 4, -1, 0);
    join
    wait_idle("fairness");
    n_checks++;
    if (n_results - r0 != 2 * NCH) begin
      n_fail++;
      $display("FAIL fairness_count: %0d results, required %0d", n_results - r0, 2 * NCH);
    end
  endtask

  task automatic test_gaps_backpressure();
    int  f0, w;
    bit  ch0_done;
    f0 = fwd_count;
    ch0_done = 1'b0;
    res_ready = 1'b0;
    push_exp(exp_mean(200, 2), 2, 1'b0);
    drive_burst(2, WS, 200, 2, 4, 3);
    w = 0;
    @(negedge clk);
    while (res_valid !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (w >= 200) begin
      n_fail++;
      $display("FAIL gaps_result_timeout: res_valid=%b, required 1", res_valid);
    end
    n_checks++;
    if (fwd_count - f0 != WS) begin
      n_fail++;
      $display("FAIL gaps_fwd_count: %0d samples forwarded, required %0d", fwd_count - f0, WS);
    end
    push_exp(exp_mean(600, 1), 0, 1'b0);
    fork
      begin
        drive_burst(0, WS, 600, 1, -1, 0);
        ch0_done = 1'b1;
      end
    join_none
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b1 || res_data !== DW'(exp_mean(200, 2)) || res_ch !== 2'd2 || req_ready !== '0) begin
        n_fail++;
        $display("FAIL backpressure_hold: rv=%b rd=%0d rc=%0d rdy=%b, required 1/%0d/2/0",
                 res_valid, res_data, res_ch, req_ready, exp_mean(200, 2));
      end
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    w = 0;
    while (!ch0_done && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) begin
      n_checks++; n_fail++;
      $display("FAIL gaps_ch0_timeout: ch0 burst done=%b, required 1", ch0_done);
    end
    wait_idle("gaps");
  endtask

  task automatic test_reset_mid_stream();
    drive_burst(0, 4, 700, 1, -1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== '0 || mu_valid_in !== 1'b0 || mu_data_in !== '0 || mu_clear_n !== 1'b1 ||
        res_valid !== 1'b0 || res_data !== '0 || res_ch !== '0) begin
      n_fail++;
      $display("FAIL async_reset: rdy=%b mvi=%b mdi=%0d clr=%b rv=%b rd=%0d rc=%0d, required 0/0/0/1/0/0/0",
               req_ready, mu_valid_in, mu_data_in, mu_clear_n, res_valid, res_data, res_ch);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b0 || mu_valid_in !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_quiet: rv=%b mvi=%b, required 0/0", res_valid, mu_valid_in);
      end
    end
    @(posedge clk);
    #1;
    push_exp(exp_mean(800, 2), 0, 1'b0);
    push_exp(exp_mean(900, 4), 3, 1'b0);
    fork
      drive_burst(0, WS, 800, 2, -1, 0);
      drive_burst(3, WS, 900, 4, -1, 0);
    join
    wait_idle("reset_mid");
  endtask

`ifdef RMEAN_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int n, c0;
    c0 = clr_runs;
    model_dis = 1'b1;
    push_exp(0, 1, 1'b1);
    drive_burst(1, WS, 50, 1, -1, 0);
    n = 0;
    do begin
      @(negedge clk);
      if (res_valid !== 1'b1) n++;
    end while (res_valid !== 1'b1 && n < 200);
    n_checks++;
    if (n != TMO) begin
      n_fail++;
      $display("FAIL timeout_cycles: %0d DRAIN cycles, required %0d", n, TMO);
    end
    wait_idle("timeout");
    model_dis = 1'b0;
    n_checks++;
    if (clr_runs - c0 != 1) begin
      n_fail++;
      $display("FAIL timeout_clear: %0d clear pulses, required 1", clr_runs - c0);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < NCH; i++) begin
      ch_valid[i] = 1'b0;
      ch_data[i]  = '0;
    end
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_gaps_backpressure();
    test_reset_mid_stream();
`ifdef RMEAN_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_results: %0d outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
